// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between the instruction-fetch requester (if_*) and
// the load/store requester (dm_*). Only one transaction is in flight at a
// time. When both ports request together, the port granted least recently
// wins. Each transaction runs a request/grant/response handshake on the mem_*
// side. The response is routed back to the port that issued the request. A
// watchdog ends a transaction whose response never arrives: it returns data 0
// and raises err_o.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req_i, if_addr_i        fetch request (held until if_gnt_o)
//   if_gnt_o                   fetch accepted (combinational, IDLE only)
//   if_rvalid_o, if_rdata_o    fetch response pulse and read data
//   dm_req_i, dm_we_i,
//   dm_addr_i, dm_wdata_i      load/store request (held until dm_gnt_o)
//   dm_gnt_o                   load/store accepted (combinational, IDLE only)
//   dm_rvalid_o, dm_rdata_o    load/store response pulse and read data
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o    registered request to memory
//   mem_gnt_i                  memory accepted the request
//   mem_rvalid_i, mem_rdata_i  memory response
//   err_o                      current rvalid pulse is a watchdog timeout
//   busy_o                     a transaction is in progress
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DAT_WIDTH  = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DAT_WIDTH-1:0]  if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DAT_WIDTH-1:0]  dm_wdata_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DAT_WIDTH-1:0]  dm_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DAT_WIDTH-1:0]  mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DAT_WIDTH-1:0]  mem_rdata_i,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int WD_WIDTH = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {PORT_IF = 1'b0, PORT_DM = 1'b1} port_t;

  state_t                state_q, state_d;
  port_t                 owner_q, last_grant_q;
  logic [WD_WIDTH-1:0]   wdog_q;
  logic                  err_q;
  logic                  mem_req_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DAT_WIDTH-1:0]  mem_wdata_q;
  logic [DAT_WIDTH-1:0]  if_rdata_q, dm_rdata_q;

  // Response capture strobe, shared by the normal and the timeout path.
  logic                  capture;
  logic [DAT_WIDTH-1:0]  capture_data;
  logic                  capture_err;

  // Next state, grants and response capture.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned (which would infer a latch).
    state_d      = state_q;
    if_gnt_o     = 1'b0;
    dm_gnt_o     = 1'b0;
    capture      = 1'b0;
    capture_data = mem_rdata_i;
    capture_err  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req_i || dm_req_i) begin
          // On a tie, the port that did not win last time gets the grant.
          if (dm_req_i && (!if_req_i || last_grant_q == PORT_IF)) begin
            dm_gnt_o = 1'b1;
          end else begin
            if_gnt_o = 1'b1;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt_i) begin
          if (mem_rvalid_i) begin
            capture = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          capture = 1'b1;
          state_d = RESP;
        end else if (wdog_q == WD_LIMIT) begin
          capture      = 1'b1;
          capture_data = '0;
          capture_err  = 1'b1;
          state_d      = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= PORT_IF;
      last_grant_q <= PORT_IF;
      wdog_q       <= '0;
      err_q        <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q <= state_d;

      // Latch the winning request. A fetch carries no write data.
      if (if_gnt_o || dm_gnt_o) begin
        owner_q      <= dm_gnt_o ? PORT_DM : PORT_IF;
        last_grant_q <= dm_gnt_o ? PORT_DM : PORT_IF;
        mem_req_q    <= 1'b1;
        mem_we_q     <= dm_gnt_o & dm_we_i;
        mem_addr_q   <= dm_gnt_o ? dm_addr_i : if_addr_i;
        mem_wdata_q  <= dm_gnt_o ? dm_wdata_i : '0;
      end else if (state_q == ISSUE && mem_gnt_i) begin
        mem_req_q <= 1'b0;
      end

      // The watchdog counts only in WAIT. It saturates instead of wrapping,
      // and it restarts from zero for every transaction.
      if (state_q == WAIT) begin
        if (wdog_q != WD_LIMIT) begin
          wdog_q <= wdog_q + 1'b1;
        end
      end else begin
        wdog_q <= '0;
      end

      // The non-owner's read data keeps its previous value.
      if (capture) begin
        err_q <= capture_err;
        if (owner_q == PORT_DM) begin
          dm_rdata_q <= capture_data;
        end else begin
          if_rdata_q <= capture_data;
        end
      end
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_rvalid_o = (state_q == RESP) && (owner_q == PORT_IF);
  assign dm_rvalid_o = (state_q == RESP) && (owner_q == PORT_DM);
  assign err_o       = (state_q == RESP) && err_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter (TIMEOUT = 4). The bench keeps a
// transaction-level reference model: at most one open transaction record,
// plus the arbitration history. Every sample() call compares all DUT outputs
// against that model. Fixed vectors and hand-written sequences add explicit
// constant checks for the tie order, the fetch/store transactions, the
// memory stall, the watchdog timeout and a reset in WAIT.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk;
  logic          rst_n;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o, if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          dm_req_i, dm_we_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic          dm_gnt_o, dm_rvalid_o;
  logic [DW-1:0] dm_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i, mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic          err_o, busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: one transaction record and the arbitration history.
  // ---------------------------------------------------------------------------
  typedef enum {P_IF, P_DM} who_t;

  bit            m_open;      // a transaction has been granted and not finished
  who_t          m_owner;
  bit            m_sent;      // memory has accepted the request
  bit            m_done;      // response captured; this cycle is the rvalid pulse
  bit            m_err;
  int            m_waited;    // cycles spent waiting after acceptance
  bit            m_last_dm;   // most recent grant went to DM
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_if_rdata, m_dm_rdata;
  bit            m_if_gnt, m_dm_gnt;

  task automatic model_reset();
    m_open = 0; m_owner = P_IF; m_sent = 0; m_done = 0; m_err = 0;
    m_waited = 0; m_last_dm = 0;
    m_addr = '0; m_we = 1'b0; m_wdata = '0;
    m_if_rdata = '0; m_dm_rdata = '0;
    m_if_gnt = 0; m_dm_gnt = 0;
  endtask

  task automatic finish_txn(input logic [DW-1:0] d, input bit e);
    m_done = 1;
    m_err  = e;
    if (m_owner == P_DM) m_dm_rdata = d;
    else                 m_if_rdata = d;
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1 after the inputs are driven. Samples at posedge+2
  // and compares every output against the model.
  task automatic sample();
    logic [7:0] exp_ctrl, act_ctrl;
    #1;
    m_if_gnt = !m_open && if_req_i && (!dm_req_i || m_last_dm);
    m_dm_gnt = !m_open && dm_req_i && (!if_req_i || !m_last_dm);
    exp_ctrl = {m_if_gnt, m_dm_gnt,
                m_open && m_done && (m_owner == P_IF),
                m_open && m_done && (m_owner == P_DM),
                m_open && m_done && m_err,
                m_open, m_open && !m_sent, m_we};
    act_ctrl = {if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o,
                err_o, busy_o, mem_req_o, mem_we_o};
    check("ctrl",       act_ctrl,    exp_ctrl);
    check("mem_addr",   mem_addr_o,  m_addr);
    check("mem_wdata",  mem_wdata_o, m_wdata);
    check("if_rdata",   if_rdata_o,  m_if_rdata);
    check("dm_rdata",   dm_rdata_o,  m_dm_rdata);
  endtask

  // Advances the model by one clock using the inputs held this cycle. Ends
  // at the following posedge+1.
  task automatic advance();
    if (rst_n) begin
      if (!m_open) begin
        if (m_if_gnt || m_dm_gnt) begin
          m_open = 1; m_sent = 0; m_done = 0; m_waited = 0;
          m_owner   = m_dm_gnt ? P_DM : P_IF;
          m_last_dm = m_dm_gnt;
          m_addr    = m_dm_gnt ? dm_addr_i : if_addr_i;
          m_we      = m_dm_gnt && dm_we_i;
          m_wdata   = m_dm_gnt ? dm_wdata_i : '0;
        end
      end else if (m_done) begin
        m_open = 0;
      end else if (!m_sent) begin
        if (mem_gnt_i) begin
          m_sent = 1;
          if (mem_rvalid_i) finish_txn(mem_rdata_i, 0);
        end
      end else if (mem_rvalid_i) begin
        finish_txn(mem_rdata_i, 0);
      end else if (m_waited == TO) begin
        finish_txn('0, 1);
      end else begin
        m_waited++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i = 0; if_addr_i = '0;
    dm_req_i = 0; dm_we_i = 0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  // Leaves the bench at posedge+1 with reset released before the next edge.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Tie vectors: both ports request continuously and memory always answers
  // in the accept cycle. Expected order: DM, IF, DM, IF, with 3 cycles per
  // transaction.
  typedef struct {
    logic if_req, dm_req, mg, mrv;
    logic e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv, e_busy;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int rv_k;
    int busy_after;
    int n_if_rv, n_dm_rv;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    check("reset_ctrl", {if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o,
                         err_o, busy_o, mem_req_o, mem_we_o}, 8'h00);
    check("reset_mem_addr", mem_addr_o, '0);
    do_reset();

    // Fetch with the minimum latency: rvalid in cycle 3.
    if_req_i = 1; if_addr_i = 32'h0000_0010;
    sample(); check("t1_if_gnt_c0", if_gnt_o, 1'b1); advance();
    if_req_i = 0; mem_gnt_i = 1;
    sample();
    check("t1_mem_req_c1", mem_req_o, 1'b1);
    check("t1_mem_addr_c1", mem_addr_o, 32'h10);
    advance();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0050_0093;
    sample(); advance();
    mem_rvalid_i = 0; mem_rdata_i = '0;
    sample();
    check("t1_if_rvalid_c3", if_rvalid_o, 1'b1);
    check("t1_if_rdata_c3", if_rdata_o, 32'h0050_0093);
    check("t1_err_c3", err_o, 1'b0);
    advance();
    sample(); check("t1_idle_c4", busy_o, 1'b0); advance();

    // Round-robin tie from reset, table driven.
    do_reset();
    if_addr_i = 32'h0000_1000; dm_addr_i = 32'h0000_2000; dm_wdata_i = 32'h55;
    for (int i = 0; i < 10; i++) begin
      if_req_i = vecs[i].if_req; dm_req_i = vecs[i].dm_req;
      mem_gnt_i = vecs[i].mg; mem_rvalid_i = vecs[i].mrv;
      mem_rdata_i = 32'hA000_0000 + 32'(i);
      sample();
      check($sformatf("tie_vec%0d", i),
            {if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, busy_o},
            {vecs[i].e_if_gnt, vecs[i].e_dm_gnt, vecs[i].e_if_rv,
             vecs[i].e_dm_rv, vecs[i].e_busy});
      advance();
    end

    // Store: a single dm_rvalid pulse and no if_rvalid.
    do_reset();
    n_if_rv = 0; n_dm_rv = 0;
    dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h100; dm_wdata_i = 32'hDEAD_BEEF;
    for (int c = 0; c < 7; c++) begin
      mem_gnt_i    = (c == 1);
      mem_rvalid_i = (c == 2);
      mem_rdata_i  = (c == 2) ? 32'h1234_5678 : 32'h0;
      sample();
      if (c == 1) begin
        check("st_mem_req", mem_req_o, 1'b1);
        check("st_mem_we", mem_we_o, 1'b1);
        check("st_mem_addr", mem_addr_o, 32'h100);
        check("st_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      end
      n_if_rv += int'(if_rvalid_o);
      n_dm_rv += int'(dm_rvalid_o);
      advance();
      if (c == 0) begin dm_req_i = 0; dm_we_i = 0; end
    end
    check("st_dm_rvalid_count", n_dm_rv, 1);
    check("st_if_rvalid_count", n_if_rv, 0);

    // Memory stall: held in ISSUE for 5 cycles. DM waits throughout and
    // wins the next arbitration. Its load then runs into the watchdog.
    if_req_i = 1; if_addr_i = 32'h200;
    sample(); check("stall_if_gnt", if_gnt_o, 1'b1); advance();
    if_req_i = 0;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h300; dm_wdata_i = 32'h77;
    for (int c = 0; c < 5; c++) begin
      sample();
      check("stall_mem_req", mem_req_o, 1'b1);
      check("stall_mem_addr", mem_addr_o, 32'h200);
      check("stall_dm_gnt", dm_gnt_o, 1'b0);
      advance();
    end
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_0001;
    sample(); advance();
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    sample(); check("stall_if_rvalid", if_rvalid_o, 1'b1); advance();
    sample(); check("to_dm_gnt", dm_gnt_o, 1'b1); advance();
    dm_req_i = 0; mem_gnt_i = 1;
    sample(); advance();
    mem_gnt_i = 0;
    rv_k = -1; busy_after = -1;
    for (int k = 0; k < 20; k++) begin
      sample();
      if (k == rv_k + 1 && rv_k >= 0) busy_after = int'(busy_o);
      if (dm_rvalid_o && rv_k < 0) begin
        rv_k = k;
        check("to_err", err_o, 1'b1);
        check("to_dm_rdata", dm_rdata_o, '0);
      end
      advance();
    end
    check("to_rvalid_cycle", rv_k, TO + 1);
    check("to_idle_after", busy_after, 0);

    // Reset in WAIT abandons the transaction.
    if_req_i = 1; if_addr_i = 32'h400;
    sample(); advance();
    if_req_i = 0; mem_gnt_i = 1;
    sample(); advance();
    mem_gnt_i = 0;
    sample(); advance();
    rst_n = 1'b0;
    #1;
    check("rst_ctrl", {if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o,
                       err_o, busy_o, mem_req_o, mem_we_o}, 8'h00);
    check("rst_mem_addr", mem_addr_o, '0);
    check("rst_if_rdata", if_rdata_o, '0);
    check("rst_dm_rdata", dm_rdata_o, '0);
    do_reset();
    n_if_rv = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_BAD0;
    for (int c = 0; c < 3; c++) begin
      sample(); n_if_rv += int'(if_rvalid_o); advance();
    end
    check("rst_no_rvalid", n_if_rv, 0);
    mem_rvalid_i = 0;
    if_req_i = 1; dm_req_i = 1;
    sample(); check("rst_tie_dm", {if_gnt_o, dm_gnt_o}, 2'b01); advance();
    if_req_i = 0; dm_req_i = 0;

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if (!if_req_i && ($urandom % 3 == 0)) begin
        if_req_i = 1; if_addr_i = $urandom;
      end
      if (!dm_req_i && ($urandom % 3 == 0)) begin
        dm_req_i = 1; dm_we_i = 1'($urandom % 2);
        dm_addr_i = $urandom; dm_wdata_i = $urandom;
      end
      mem_gnt_i    = ($urandom % 3) != 0;
      mem_rvalid_i = ($urandom % 4) == 0;
      mem_rdata_i  = $urandom;
      sample();
      advance();
      if (m_if_gnt) if_req_i = 0;
      if (m_dm_gnt) dm_req_i = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one unified memory port between the CPU's instruction-fetch requester and its load/store requester. Requests are accepted with round-robin fairness, and only one transaction is outstanding at a time. Each transaction is forwarded through a request/grant/response handshake, and the response is routed back to the requester that issued it. A watchdog terminates any transaction whose response never arrives. The block sits between the core's fetch/data interfaces and a single-port memory.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DAT_WIDTH, 32, data width of all ports
- TIMEOUT, 255, maximum cycles spent in WAIT before forced error completion (1..65535)

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request; held high with if_addr_i stable until if_gnt_o
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch response valid, one-cycle pulse
- if_rdata_o  out  DAT_WIDTH  fetch read data
- dm_req_i  in  1  data request; held with dm_we_i, dm_addr_i and dm_wdata_i stable until dm_gnt_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  ADDR_WIDTH  data address
- dm_wdata_i  in  DAT_WIDTH  store data
- dm_gnt_o  out  1  data request accepted this cycle
- dm_rvalid_o  out  1  data response valid, one-cycle pulse; also issued for stores
- dm_rdata_o  out  DAT_WIDTH  load data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DAT_WIDTH  memory write data
- mem_gnt_i  in  1  memory accepted the request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  DAT_WIDTH  memory read data
- err_o  out  1  qualifies the current rvalid pulse as a timeout
- busy_o  out  1  state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, no requests: stay in IDLE.
- IDLE, at least one request:
  - Select the owner.
  - Drive the owner's gnt_o combinationally in this same cycle.
  - At the clock edge, latch addr, we and wdata (fetch: we=0, wdata=0), record owner and last_grant, and go to ISSUE.
- Owner selection:
  - Single requester: that requester.
  - Both requesting: the port that is not last_grant.
  - last_grant resets to IF, so the first tie goes to DM.
- ISSUE:
  - mem_req_o=1 with the latched fields.
  - mem_gnt_i=0: stay in ISSUE.
  - mem_gnt_i=1 with mem_rvalid_i=0: go to WAIT.
  - mem_gnt_i=1 with mem_rvalid_i=1: capture the response and go to RESP.
- WAIT:
  - mem_req_o=0; a watchdog counter increments every cycle.
  - mem_rvalid_i=1: capture mem_rdata_i, clear the error flag, go to RESP.
  - Counter reaches TIMEOUT with no response: capture data 0, set the error flag, go to RESP.
- RESP:
  - The owner's rvalid_o=1 for exactly one cycle; err_o carries the error flag.
  - Then go to IDLE.
- Response data:
  - The owner's rdata_o updates when the response is captured.
  - The non-owner's rdata_o keeps its last value.
  - For stores, dm_rdata_o is updated with the captured mem_rdata_i; it is don't-care to the requester.
- mem_rvalid_i in IDLE or RESP, or in ISSUE while mem_gnt_i=0: ignored, no state change.
- gnt_o is never asserted outside IDLE; requests arriving while busy wait, held by the requester.

## Timing
- Reset (asynchronous assert, synchronous release effect):
  - State = IDLE, last_grant = IF, watchdog = 0.
  - All outputs 0, including rdata_o, mem_addr_o, mem_wdata_o, err_o and busy_o.
  - Reset mid-transaction abandons the transaction; no rvalid is emitted.
- Minimum transaction, with gnt in cycle 0:
  - ISSUE in cycle 1.
  - mem_gnt_i in cycle 1, mem_rvalid_i in cycle 2.
  - rvalid_o in cycle 3.
  - Next grant possible in cycle 4.
- With mem_gnt_i and mem_rvalid_i in the same cycle (cycle 1): rvalid_o in cycle 2, next grant in cycle 3.
- Throughput: at most one transaction per 3 cycles.
- Timeout: WAIT is entered in cycle t; the forced RESP (err_o=1) occurs in cycle t+TIMEOUT+1.
- Width: the watchdog counter is $clog2(TIMEOUT+1) bits and saturates; there is no wrap.
- mem_* outputs are registered; gnt_o is combinational from req_i and state.

## Test plan
- Reset release, then if_req_i=1, addr=0x0000_0010 -> if_gnt_o high in cycle 0; mem_req_o=1 with addr 0x10 in cycle 1. With mem_gnt_i=1 in cycle 1 and mem_rvalid_i=1, rdata=0x0050_0093 in cycle 2: if_rvalid_o=1 and if_rdata_o=0x0050_0093 in cycle 3, err_o=0.
- if_req_i and dm_req_i high together, continuously, after reset -> grants in order DM, IF, DM, IF; no port is granted twice in a row while both are requesting.
- Store: dm_we_i=1, addr=0x100, wdata=0xDEAD_BEEF -> mem_we_o=1, mem_addr_o=0x100, mem_wdata_o=0xDEAD_BEEF. dm_rvalid_o pulses once; if_rvalid_o stays 0.
- mem_gnt_i held low for 5 cycles -> stays in ISSUE with mem_req_o and fields stable; no gnt_o to the other port meanwhile.
- TIMEOUT=4, mem_rvalid_i never asserted -> dm_rvalid_o=1 with err_o=1 and dm_rdata_o=0, 5 cycles after entering WAIT; back to IDLE next cycle.
- rst_n asserted while in WAIT -> all outputs 0 immediately; no rvalid after release; the next tie grants DM.
